// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Reset vector, fetch FSM encoding and the canonical NOP.
package ifu_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_KILL = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_inst_fifo.sv
// Instruction buffer between fetch and decode.
// Head entry is held in a register so decode sees flop outputs.
module ifu_inst_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [$clog2(DEPTH):0] count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_nxt;
    logic [AW:0]      cnt_nxt;
    logic [WIDTH-1:0] head_nxt;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop & (count != '0);
    assign push_ok = push & ((count < DEPTH_C) | pop_ok);
    assign rd_nxt  = rd_ptr + AW'(pop_ok);
    assign cnt_nxt = count + CW'(push_ok) - CW'(pop_ok);

    // A push into a slot that becomes the head bypasses the array.
    always_comb begin
        head_nxt = mem[rd_nxt];
        if (push_ok && (wr_ptr == rd_nxt)) begin
            head_nxt = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
        end else begin
            rd_ptr     <= rd_nxt;
            wr_ptr     <= wr_ptr + AW'(push_ok);
            count      <= cnt_nxt;
            head_valid <= (cnt_nxt != '0);
            if (cnt_nxt != '0) begin
                head_data <= head_nxt;
            end
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Sequential fetch with one outstanding imem request.
// Redirects flush the buffer and kill any in-flight response.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0] DEPTH_C = CW'(BUF_DEPTH);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic [31:0]  req_pc;
    logic         req_valid_q;
    logic         hs;
    logic         push;
    logic         pop;
    logic         room;
    logic [AW:0]  count;
    logic [AW:0]  cnt_nxt;
    logic [63:0]  head;

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = fetch_pc;
    assign hs   = req_valid_q & imem_req_ready;
    assign push = (state == FS_WAIT) & imem_resp_valid
                & ~redirect_valid;
    assign pop  = inst_valid & inst_ready;

    always_comb begin
        cnt_nxt = '0;
        if (!redirect_valid) begin
            cnt_nxt = count + CW'(push) - CW'(pop);
        end
    end

    // Full buffer only stalls new requests; WAIT owns a reserved slot.
    assign room = (cnt_nxt < DEPTH_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FS_REQ;
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            req_valid_q <= 1'b0;
        end else begin
            if (hs) begin
                req_pc <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc <= word_align(redirect_pc);
            end else if (hs) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            unique case (state)
                FS_REQ: begin
                    if (hs) begin
                        state       <= redirect_valid ? FS_KILL : FS_WAIT;
                        req_valid_q <= 1'b0;
                    end else begin
                        state       <= FS_REQ;
                        req_valid_q <= room;
                    end
                end
                FS_WAIT: begin
                    if (imem_resp_valid) begin
                        state       <= FS_REQ;
                        req_valid_q <= room;
                    end else begin
                        state       <= redirect_valid ? FS_KILL : FS_WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                FS_KILL: begin
                    if (imem_resp_valid) begin
                        state       <= FS_REQ;
                        req_valid_q <= room;
                    end else begin
                        req_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= FS_REQ;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    ifu_inst_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (push),
        .push_data  ({req_pc, imem_resp_data}),
        .pop        (pop),
        .count      (count),
        .head_valid (inst_valid),
        .head_data  (head)
    );

    assign inst_pc = head[63:32];
    assign inst    = head[31:0];

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch against a transaction-level model.
// Model: queue of buffered PCs, one outstanding request, stale flag.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    ifu_fetch #(
        .RESET_PC  (RPC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    logic [31:0] q[$];
    logic [31:0] pop_pc[$];
    int          pop_cyc[$];
    logic [31:0] hs_addr[$];
    bit          outst, stale, live;
    logic [31:0] exp_req, pend_pc, mem_addr;
    bit          mem_pend;
    int          mem_wait;
    int          p_rdy, p_ird, p_redir, min_dly, max_dly;
    bit          f_redir;
    logic [31:0] f_tgt;
    int          cyc = 0;

    task automatic model_clear();
        q.delete();
        outst    = 0;
        stale    = 0;
        live     = 0;
        mem_pend = 0;
        exp_req  = RPC;
    endtask

    task automatic zero_inputs();
        imem_req_ready  = 0;
        imem_resp_valid = 0;
        imem_resp_data  = 0;
        redirect_valid  = 0;
        redirect_pc     = 0;
        inst_ready      = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rv"}, 32'(imem_req_valid), 0);
        chk({tag, "_iv"}, 32'(inst_valid), 0);
        chk({tag, "_inst"}, inst, 0);
        chk({tag, "_pc"}, inst_pc, 0);
    endtask

    task automatic step();
        bit exp_rv, hs, pop;
        @(negedge clk);
        imem_req_ready = ($urandom_range(0, 99) < p_rdy);
        inst_ready     = ($urandom_range(0, 99) < p_ird);
        if (mem_pend && mem_wait == 0) begin
            imem_resp_valid = 1;
            imem_resp_data  = mem_word(mem_addr);
        end else begin
            imem_resp_valid = 0;
            imem_resp_data  = $urandom;
            if (mem_pend) mem_wait--;
        end
        if (f_redir) begin
            redirect_valid = 1;
            redirect_pc    = f_tgt;
            f_redir        = 0;
        end else begin
            redirect_valid = ($urandom_range(0, 99) < p_redir);
            redirect_pc    = $urandom;
        end
        #1;
        chk("inst_valid", 32'(inst_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("inst_pc", inst_pc, q[0]);
            chk("inst", inst, mem_word(q[0]));
        end
        exp_rv = live && !outst && (q.size() < DEPTH);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv && imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
        hs  = exp_rv && imem_req_ready;
        pop = (q.size() > 0) && inst_ready;
        if (pop) begin
            pop_pc.push_back(q[0]);
            pop_cyc.push_back(cyc);
            void'(q.pop_front());
        end
        if (imem_resp_valid) begin
            if (!stale && !redirect_valid) q.push_back(pend_pc);
            outst    = 0;
            mem_pend = 0;
        end
        if (hs) begin
            hs_addr.push_back(imem_req_addr);
            outst    = 1;
            stale    = 0;
            pend_pc  = exp_req;
            exp_req  = exp_req + 32'd4;
            mem_pend = 1;
            mem_addr = imem_req_addr;
            mem_wait = $urandom_range(min_dly, max_dly);
        end
        if (redirect_valid) begin
            q.delete();
            exp_req = word_align(redirect_pc);
            if (outst) stale = 1;
        end
        live = 1;
        cyc++;
        @(posedge clk);
    endtask

    initial begin
        rst_n = 0;
        zero_inputs();
        model_clear();
        p_rdy = 100; p_ird = 100; p_redir = 0;
        min_dly = 0; max_dly = 0; f_redir = 0; f_tgt = 0;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        @(posedge clk);
        #2 rst_n = 1;

        // sequential fetch, 1-cycle memory
        repeat (12) step();
        chk("p1_pops", 32'(pop_pc.size() >= 3), 1);
        if (pop_pc.size() >= 3) begin
            chk("p1_pc0", pop_pc[0], 32'h8000_0000);
            chk("p1_pc1", pop_pc[1], 32'h8000_0004);
            chk("p1_pc2", pop_pc[2], 32'h8000_0008);
            chk("p1_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 2);
            chk("p1_gap2", 32'(pop_cyc[2] - pop_cyc[1]), 2);
        end

        // decode stall fills the buffer
        p_ird = 0;
        repeat (20) step();
        #1;
        chk("full_cnt", 32'(q.size()), DEPTH);
        chk("full_noreq", 32'(imem_req_valid), 0);
        p_ird = 100;
        pop_pc.delete();
        repeat (12) step();
        for (int i = 1; i < pop_pc.size(); i++)
            chk("resume_seq", pop_pc[i], pop_pc[i-1] + 32'd4);

        // redirect while waiting, late response
        min_dly = 2; max_dly = 2;
        for (int i = 0; i < 20 && !outst; i++) step();
        chk("p3_wait", 32'(outst), 1);
        f_redir = 1; f_tgt = 32'h8000_0100;
        hs_addr.delete();
        step();
        min_dly = 0; max_dly = 0;
        pop_pc.delete();
        repeat (10) step();
        chk("p3_req", hs_addr.size() > 0 ? hs_addr[0] : 0, 32'h8000_0100);
        chk("p3_pc", pop_pc.size() > 0 ? pop_pc[0] : 0, 32'h8000_0100);

        // redirect with request handshake and buffered head
        p_ird = 0;
        for (int i = 0; i < 20 && !(q.size() == 1 && !outst); i++) step();
        chk("p4_setup", 32'(q.size() == 1 && !outst), 1);
        f_redir = 1; f_tgt = 32'h8000_0400; p_ird = 100;
        step();
        #1;
        chk("p4_flush_iv", 32'(inst_valid), 0);
        chk("p4_kill_rv", 32'(imem_req_valid), 0);
        repeat (8) step();

        // alignment and address wrap
        p_rdy = 0;
        repeat (4) step();
        f_redir = 1; f_tgt = 32'h8000_0203;
        step();
        #1 chk("align_addr", imem_req_addr, 32'h8000_0200);
        f_redir = 1; f_tgt = 32'hffff_fffc;
        step();
        #1 chk("wrap_pre", imem_req_addr, 32'hffff_fffc);
        p_rdy = 100;
        hs_addr.delete();
        repeat (6) step();
        chk("wrap_addr", hs_addr.size() > 1 ? hs_addr[1] : 32'hdead_beef, 0);

        // reset in WAIT with a buffered entry
        p_ird = 0; min_dly = 5; max_dly = 5;
        for (int i = 0; i < 30 && !(q.size() == 1 && outst); i++) step();
        chk("p6_setup", 32'(q.size() == 1 && outst), 1);
        #2 rst_n = 0;
        zero_inputs();
        #1 chk_zero("midrst");
        model_clear();
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        min_dly = 0; max_dly = 0; p_ird = 100;
        hs_addr.delete();
        repeat (8) step();
        chk("p6_req", hs_addr.size() > 0 ? hs_addr[0] : 0, RPC);

        // random traffic
        p_rdy = 70; p_ird = 60; p_redir = 5;
        min_dly = 0; max_dly = 3;
        repeat (2000) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
